serial_parity_rx: RTL and testbench
===================================

// Module: serial_parity_rx
// PURPOSE
//   Receiving end of the team's XOR-parity serial link. Deserialises one frame:
//   start(0), DATA_W data bits LSB-first, parity, stop(1).
//   Checks the parity bit against a running XOR of the data bits.
//   Presents the word with parity and framing error flags to downstream logic.
// PARAMETERS
//   DATA_W        8   data bits per frame (1..16)
//   CLKS_PER_BIT  16  clk cycles per serial bit; even, >= 4
//   PARITY_ODD    0   0: even parity (XOR of data ^ parity == 0); 1: odd parity (== 1)
// PORTS
//   clk         in   1       single system clock, rising edge
//   rst         in   1       asynchronous, active-high reset
//   rx_in       in   1       serial line, idle high, asynchronous to clk
//   data_out    out  DATA_W  last received word
//   data_valid  out  1       one-cycle pulse: data_out/flags updated this cycle
//   parity_err  out  1       parity mismatch on last frame; held until next data_valid
//   frame_err   out  1       stop bit sampled 0 on last frame; held until next data_valid
//   busy        out  1       high whenever FSM is not IDLE
// BEHAVIOUR
//   Reset: data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0.
//     Synchroniser flops reset to 1, FSM resets to IDLE.
//     Reset at any point, including mid-frame, aborts the frame with no data_valid.
//   Sync: rx_in passes through a 2-flop synchroniser -> rx_s (2-cycle lag). All decisions use rx_s.
//   Timing: C=CLKS_PER_BIT, H=C/2. Cycle 0 is the first cycle rx_s=0 seen in IDLE.
//     Start bit sampled at cycle H.
//     Data bit i (i=0..DATA_W-1) sampled at H+(i+1)*C.
//     Parity bit sampled at H+(DATA_W+1)*C.
//     Stop bit sampled at H+(DATA_W+2)*C.
//     data_valid=1 at H+(DATA_W+2)*C+1.
//   FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
//     IDLE   -> START on rx_s==0; clear bit counter, parity accumulator, cycle counter.
//     START  -> at sample: rx_s==1 -> IDLE (glitch; no data_valid, flags unchanged).
//              rx_s==0 -> DATA.
//     DATA   -> shift rx_s into shift reg MSB (LSB-first line order); acc ^= rx_s.
//              After bit DATA_W-1 -> PARITY.
//     PARITY -> perr = acc ^ rx_s ^ PARITY_ODD; -> STOP.
//     STOP   -> at sample: latch data_out, parity_err=perr, frame_err=~rx_s; pulse data_valid next cycle.
//              rx_s==1 -> IDLE; rx_s==0 -> BREAK.
//     BREAK  -> wait for rx_s==1, then IDLE. No further frames are started while in BREAK.
//   Frame with both errors reports both flags; data_out is still updated.
//   The cycle counter wraps 0..C-1 between samples; no other counter overflow is possible.
//   A new start is accepted the first cycle after returning to IDLE (back-to-back frames OK).
//   rx_in activity during DATA/PARITY/STOP affects only the sampled values; there is no mid-bit resync.
//   data_valid is never high for two consecutive cycles. There is no backpressure: the consumer must capture on the pulse.
// TESTING (DATA_W=8, C=4 unless noted; rx_in driven via bench model with C-cycle bits)
//   1 Frame 0xA5, parity 0, stop 1 -> one data_valid, data_out=0xA5, parity_err=0, frame_err=0, busy low after.
//   2 Frame 0x01, parity 0 (should be 1) -> data_out=0x01, parity_err=1; next good frame 0x3C clears it to 0.
//   3 Frame 0xFF, parity 0, stop 0 held low 20 cycles -> frame_err=1, busy stays 1 until rx high, then 0.
//   4 rx_in low for 1 cycle only -> no data_valid, busy pulses then 0, outputs unchanged.
//   5 rst asserted at data bit 4 of frame 0x55 -> all outputs 0 immediately, no data_valid. Next frame 0x96 received correctly.
//   6 PARITY_ODD=1, back-to-back frames 0x00/par 1 and 0x07/par 0 -> two data_valid pulses exactly (DATA_W+3)*C cycles apart, both parity_err=0.
//   Check data_valid cycle against the timing formula above on every frame.

Source files
------------

// File: rtl/serial_parity_rx.sv
// Receiver for the XOR-parity serial link: start, DATA_W data bits LSB-first, parity, stop.
// Reports each received word with a one-cycle data_valid pulse plus held parity/framing flags.
module serial_parity_rx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int   H     = CLKS_PER_BIT / 2;
    localparam int   CNT_W = $clog2(CLKS_PER_BIT);
    localparam int   BIT_W = $clog2(DATA_W + 1);
    localparam logic ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t            state_q, state_d;
    logic              sync1_q, rx_s;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              acc_q, acc_d;
    logic              perr_q, perr_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic              data_valid_q, data_valid_d;
    logic              mid_bit;

    // Synchroniser flops reset to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            rx_s    <= sync1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            acc_q        <= 1'b0;
            perr_q       <= 1'b0;
            data_out_q   <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            acc_q        <= acc_d;
            perr_q       <= perr_d;
            data_out_q   <= data_out_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            data_valid_q <= data_valid_d;
        end
    end

    // The start bit is sampled half a bit in; every later sample lands one full bit after the previous.
    assign mid_bit = (state_q == START) ? (cnt_q == CNT_W'(H - 1))
                                        : (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        acc_d        = acc_q;
        perr_d       = perr_q;
        data_out_d   = data_out_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        data_valid_d = 1'b0;
        if (mid_bit) begin
            cnt_d = '0;
        end
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d   = START;
                    bit_cnt_d = '0;
                    acc_d     = 1'b0;
                end
            end
            START: begin
                if (mid_bit) begin
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (mid_bit) begin
                    shift_d = (shift_q >> 1) | (DATA_W'(rx_s) << (DATA_W - 1));
                    acc_d   = acc_q ^ rx_s;
                    if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
                        state_d = PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (mid_bit) begin
                    perr_d  = acc_q ^ rx_s ^ ODD;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (mid_bit) begin
                    data_out_d   = shift_q;
                    parity_err_d = perr_q;
                    frame_err_d  = ~rx_s;
                    data_valid_d = 1'b1;
                    state_d      = rx_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_parity_rx.sv
// Self-checking bench for serial_parity_rx: table vectors, hand-written corner cases and
// random frames, all scored against a frame-level reference model with expected arrival cycles.
module tb_serial_parity_rx;

    localparam int DATA_W     = 8;
    localparam int C          = 4;
    localparam int H          = C / 2;
    localparam int FRAME_BITS = DATA_W + 3;
    // From the cycle rx_in falls to the cycle data_valid is high: 2 sync stages + stop sample + 1.
    localparam int DV_LAT     = 2 + H + (DATA_W + 2) * C + 1;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         extra_low;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, rst_o;
    logic       rx_in, rx_o;
    logic [7:0] data_out, data_out_o;
    logic       data_valid, parity_err, frame_err, busy;
    logic       data_valid_o, parity_err_o, frame_err_o, busy_o;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t exp_o_q[$];
    int   dvo_times[$];
    logic prev_dv = 1'b0;
    logic prev_dv_o = 1'b0;
    vec_t vecs[7];

    serial_parity_rx #(.DATA_W(DATA_W), .CLKS_PER_BIT(C), .PARITY_ODD(0)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .data_out(data_out), .data_valid(data_valid),
        .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
    );

    serial_parity_rx #(.DATA_W(DATA_W), .CLKS_PER_BIT(C), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .rst(rst_o), .rx_in(rx_o), .data_out(data_out_o), .data_valid(data_valid_o),
        .parity_err(parity_err_o), .frame_err(frame_err_o), .busy(busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference: a frame is good when the count of ones over data+parity has the configured parity.
    function automatic exp_t model(input logic [7:0] d, input logic par, input logic stop, input bit odd);
        exp_t m;
        m.cyc  = 0;
        m.data = d;
        m.perr = ((($countones(d) + int'(par)) % 2) != (odd ? 1 : 0));
        m.ferr = !stop;
        return m;
    endfunction

    // Every data_valid pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (data_valid) begin
            checkOutput("dv pulse width", int'(prev_dv), 0);
            if (exp_q.size() == 0) begin
                checkOutput("unexpected data_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("dv cycle", cyc, e.cyc);
                checkOutput("data_out", int'(data_out), int'(e.data));
                checkOutput("parity_err", int'(parity_err), int'(e.perr));
                checkOutput("frame_err", int'(frame_err), int'(e.ferr));
            end
        end
        if (data_valid_o) begin
            checkOutput("odd dv pulse width", int'(prev_dv_o), 0);
            dvo_times.push_back(cyc);
            if (exp_o_q.size() == 0) begin
                checkOutput("odd unexpected data_valid", 1, 0);
            end else begin
                e = exp_o_q.pop_front();
                checkOutput("odd dv cycle", cyc, e.cyc);
                checkOutput("odd data_out", int'(data_out_o), int'(e.data));
                checkOutput("odd parity_err", int'(parity_err_o), int'(e.perr));
                checkOutput("odd frame_err", int'(frame_err_o), int'(e.ferr));
            end
        end
        prev_dv   = data_valid;
        prev_dv_o = data_valid_o;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic setLine(input bit sel, input logic v);
        if (sel) rx_o = v;
        else rx_in = v;
    endtask

    // Drives one whole frame, C cycles per bit, after queueing its expected result.
    task automatic applyStimulus(input bit sel, input logic [7:0] data, input logic par,
                                 input logic stop, input int extra_low, input exp_t e);
        logic [FRAME_BITS-1:0] bits;
        bits  = {stop, par, data, 1'b0};
        e.cyc = cyc + DV_LAT;
        if (sel) exp_o_q.push_back(e);
        else exp_q.push_back(e);
        for (int j = 0; j < FRAME_BITS; j++) begin
            setLine(sel, bits[j]);
            waitCycles(C);
        end
        if (!stop && extra_low > 0) begin
            waitCycles(extra_low / 2);
            checkOutput("busy in break", int'(sel ? busy_o : busy), 1);
            waitCycles(extra_low - extra_low / 2);
        end
        setLine(sel, 1'b1);
    endtask

    initial begin
        exp_t e;
        logic [7:0] d;
        logic       p, s;
        int         x;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 0,  8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 1'b0, 1'b1, 0,  8'h01, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b1, 0,  8'h3C, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 1'b0, 20, 8'hFF, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 1'b0, 1'b0, 4,  8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 1'b0, 1'b1, 0,  8'h00, 1'b0, 1'b0};
        vecs[6] = '{8'hFE, 1'b1, 1'b1, 0,  8'hFE, 1'b0, 1'b0};

        rst = 1'b1; rst_o = 1'b1; rx_in = 1'b1; rx_o = 1'b1;
        waitCycles(3);
        checkOutput("reset data_out", int'(data_out), 0);
        checkOutput("reset data_valid", int'(data_valid), 0);
        checkOutput("reset parity_err", int'(parity_err), 0);
        checkOutput("reset frame_err", int'(frame_err), 0);
        checkOutput("reset busy", int'(busy), 0);
        rst = 1'b0; rst_o = 1'b0;
        waitCycles(3);

        foreach (vecs[i]) begin
            e.cyc  = 0;
            e.data = vecs[i].exp_data;
            e.perr = vecs[i].exp_perr;
            e.ferr = vecs[i].exp_ferr;
            applyStimulus(1'b0, vecs[i].data, vecs[i].par, vecs[i].stop, vecs[i].extra_low, e);
            waitCycles(4);
            checkOutput("idle busy", int'(busy), 0);
            checkOutput("held data_out", int'(data_out), int'(vecs[i].exp_data));
            checkOutput("held parity_err", int'(parity_err), int'(vecs[i].exp_perr));
            checkOutput("held frame_err", int'(frame_err), int'(vecs[i].exp_ferr));
        end

        // One-cycle glitch: START is entered, then abandoned at the half-bit sample.
        rx_in = 1'b0;
        waitCycles(1);
        rx_in = 1'b1;
        waitCycles(2);
        checkOutput("glitch busy", int'(busy), 1);
        waitCycles(4);
        checkOutput("glitch busy after", int'(busy), 0);
        checkOutput("glitch data_out", int'(data_out), 8'hFE);
        checkOutput("glitch parity_err", int'(parity_err), 0);

        // Reset in the middle of data bit 4 of 0x55 aborts the frame silently.
        d = 8'h55;
        rx_in = 1'b0;
        waitCycles(C);
        for (int j = 0; j < 4; j++) begin
            rx_in = d[j];
            waitCycles(C);
        end
        rx_in = d[4];
        waitCycles(H);
        rst = 1'b1;
        #1;
        checkOutput("mid reset data_out", int'(data_out), 0);
        checkOutput("mid reset busy", int'(busy), 0);
        checkOutput("mid reset data_valid", int'(data_valid), 0);
        rx_in = 1'b1;
        waitCycles(3);
        rst = 1'b0;
        waitCycles(3);
        e = '{0, 8'h96, 1'b0, 1'b0};
        applyStimulus(1'b0, 8'h96, 1'b0, 1'b1, 0, e);
        waitCycles(4);

        // Random frames scored by the model; a short idle gap lets BREAK see the line high.
        for (int n = 0; n < 16; n++) begin
            d = 8'($urandom);
            p = 1'($urandom);
            s = ($urandom_range(0, 3) != 0);
            x = s ? 0 : int'($urandom_range(4, 8));
            applyStimulus(1'b0, d, p, s, x, model(d, p, s, 1'b0));
            waitCycles(int'($urandom_range(1, 3)));
        end

        // Odd parity, back-to-back frames with no idle between them.
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b1, 0, model(8'h00, 1'b1, 1'b1, 1'b1));
        applyStimulus(1'b1, 8'h07, 1'b0, 1'b1, 0, model(8'h07, 1'b0, 1'b1, 1'b1));

        for (int i = 0; i < 200 && (exp_q.size() + exp_o_q.size()) != 0; i++) begin
            waitCycles(1);
        end
        checkOutput("pending frames", exp_q.size() + exp_o_q.size(), 0);
        if (dvo_times.size() == 2) begin
            checkOutput("b2b interval", dvo_times[1] - dvo_times[0], FRAME_BITS * C);
        end else begin
            checkOutput("b2b pulse count", dvo_times.size(), 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
